ps2_scancode_decoder: RTL
=========================

Name: ps2_scancode_decoder

Overview:
- Consumes raw PS/2 set-2 bytes from the ps2_keyboard FIFO through its ready/nextdata_n pop handshake.
- Resolves make, break (F0) and extended (E0) sequences.
- Tracks the currently held key and its ASCII value, and counts distinct key presses.
- Outputs feed the seg block (scancode, ASCII and count display) and the ledr indicators.

Parameters:
COUNT_W, 8, width of press counter key_count; wraps modulo 2^COUNT_W.

Ports:
clk  in  1  system clock
resetn  in  1  synchronous reset, active-low
ps2_data_i  in  8  byte at ps2_keyboard FIFO head; valid while ps2_ready_i=1
ps2_ready_i  in  1  FIFO non-empty
ps2_overflow_i  in  1  FIFO overflow flag from ps2_keyboard
nextdata_n  out  1  active-low pop strobe to ps2_keyboard
key_down  out  1  a key is currently held
cur_code  out  8  scancode of last pressed key (without E0 prefix)
cur_ext  out  1  last pressed key was E0-prefixed
cur_ascii  out  8  ASCII of cur_code; 0x00 if unmapped or cur_ext=1
key_count  out  COUNT_W  number of distinct presses since reset
press_pulse  out  1  one-cycle strobe on each counted press
err_overflow  out  1  sticky overflow seen

Behaviour:
- Clocking and reset:
  - All state updates on the rising clk edge.
  - resetn=0 at an edge: nextdata_n=1, every other output 0, pending flags cleared, FSM to IDLE.
  - Reset in the middle of an E0/F0 sequence drops the partial sequence. No pop is issued while resetn=0.
- FSM, 3 states:
  - IDLE: if ps2_ready_i=1, go to POP.
  - POP: nextdata_n=0 for exactly this one cycle. ps2_data_i is captured and processed at the closing edge. Go to GAP.
  - GAP: nextdata_n=1. Go to IDLE. This gives the FIFO one cycle to update ready.
  - Throughput is at most one byte per 3 cycles.
  - nextdata_n is registered and is never 0 in two consecutive cycles.
- Byte processing (at the POP closing edge):
  - 0xE0: set ext_pend=1.
  - 0xF0: set brk_pend=1.
  - Other byte with brk_pend=1 (release):
    - If key_down=1, code==cur_code and ext_pend==cur_ext: key_down<=0.
    - Otherwise ignore (release of a non-current key).
    - Clear ext_pend and brk_pend.
  - Other byte with brk_pend=0 (make):
    - If key_down=1, code==cur_code and ext_pend==cur_ext: typematic repeat; no count, no pulse.
    - Else: cur_code<=code, cur_ext<=ext_pend, key_down<=1, key_count<=key_count+1 (wraps all-ones to 0), press_pulse<=1 for the next cycle only.
    - Clear ext_pend.
  - E0 followed by F0 forms an extended break; both pending flags may be set together.
- ASCII: registered lookup, updated in the same cycle as cur_code.
  - Set-2 lowercase letters a–z (e.g. 0x1C→0x61, 0x32→0x62, 0x1A→0x7A).
  - Main-row digits (0x45→0x30, 0x16→0x31 … 0x46→0x39).
  - 0x29→0x20, 0x5A→0x0D.
  - Everything else→0x00. cur_ext=1 forces 0x00.
- err_overflow: set on any cycle with ps2_overflow_i=1; held until reset.
- Decoding continues normally after an overflow.
- Release leaves cur_code, cur_ext and cur_ascii unchanged; the display keeps the last key.

Test Plan:
- Reset then single byte 0x1C (ready high, then low after pop) → exactly one nextdata_n=0 cycle; afterwards key_down=1, cur_code=0x1C, cur_ascii=0x61, key_count=1, press_pulse high for one cycle.
- Sequence 0x1C,0x1C,0x1C,0xF0,0x1C → key_count=1, key_down=0 at end, cur_code still 0x1C; nextdata_n low exactly 5 cycles total, never back-to-back.
- Sequence 0xE0,0x75,0xE0,0xF0,0x75 → cur_ext=1, cur_code=0x75, cur_ascii=0x00, key_count=1, key_down=0 at end.
- Press 0x16, press 0x1E without release, then 0xF0,0x16 → key_count=2, cur_code=0x1E, key_down stays 1 (stale release ignored). Preload key_count to 255 via repeated distinct presses; next distinct press → key_count=0.
- Feed 0xE0,0xF0, then assert resetn=0 one cycle, then feed 0x45 → no release applied; make of 0x45, cur_ascii=0x30, cur_ext=0, key_count=1.
- Pulse ps2_overflow_i one cycle → err_overflow=1 and stays 1 through later decoding; cleared only by resetn=0.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: pops PS/2 set-2 bytes and tracks the held key, its ASCII value and the press count.
module ps2_scancode_decoder #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         ps2_data_i,
  input  logic               ps2_ready_i,
  input  logic               ps2_overflow_i,
  output logic               nextdata_n,
  output logic               key_down,
  output logic [7:0]         cur_code,
  output logic               cur_ext,
  output logic [7:0]         cur_ascii,
  output logic [COUNT_W-1:0] key_count,
  output logic               press_pulse,
  output logic               err_overflow
);
  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;
  state_t state_q, state_d;
  logic ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic key_down_q, key_down_d, cur_ext_q, cur_ext_d;
  logic [7:0] cur_code_q, cur_code_d, cur_ascii_q, cur_ascii_d;
  logic [COUNT_W-1:0] key_count_q, key_count_d;
  logic press_pulse_q, press_pulse_d, err_q, err_d, nextdata_n_q, nextdata_n_d;
  logic same;
  function automatic logic [7:0] to_ascii(input logic [7:0] c);
    case (c)
      8'h1C: to_ascii = 8'h61; 8'h32: to_ascii = 8'h62; 8'h21: to_ascii = 8'h63;
      8'h23: to_ascii = 8'h64; 8'h24: to_ascii = 8'h65; 8'h2B: to_ascii = 8'h66;
      8'h34: to_ascii = 8'h67; 8'h33: to_ascii = 8'h68; 8'h43: to_ascii = 8'h69;
      8'h3B: to_ascii = 8'h6A; 8'h42: to_ascii = 8'h6B; 8'h4B: to_ascii = 8'h6C;
      8'h3A: to_ascii = 8'h6D; 8'h31: to_ascii = 8'h6E; 8'h44: to_ascii = 8'h6F;
      8'h4D: to_ascii = 8'h70; 8'h15: to_ascii = 8'h71; 8'h2D: to_ascii = 8'h72;
      8'h1B: to_ascii = 8'h73; 8'h2C: to_ascii = 8'h74; 8'h3C: to_ascii = 8'h75;
      8'h2A: to_ascii = 8'h76; 8'h1D: to_ascii = 8'h77; 8'h22: to_ascii = 8'h78;
      8'h35: to_ascii = 8'h79; 8'h1A: to_ascii = 8'h7A;
      8'h45: to_ascii = 8'h30; 8'h16: to_ascii = 8'h31; 8'h1E: to_ascii = 8'h32;
      8'h26: to_ascii = 8'h33; 8'h25: to_ascii = 8'h34; 8'h2E: to_ascii = 8'h35;
      8'h36: to_ascii = 8'h36; 8'h3D: to_ascii = 8'h37; 8'h3E: to_ascii = 8'h38;
      8'h46: to_ascii = 8'h39;
      8'h29: to_ascii = 8'h20; 8'h5A: to_ascii = 8'h0D;
      default: to_ascii = 8'h00;
    endcase
  endfunction
  assign same = key_down_q && ps2_data_i == cur_code_q && ext_pend_q == cur_ext_q;
  always_comb begin
    state_d = state_q == IDLE ? (ps2_ready_i ? POP : IDLE) : state_q == POP ? GAP : IDLE;
    nextdata_n_d = state_d != POP;
    err_d = err_q | ps2_overflow_i;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    key_down_d = key_down_q;
    cur_code_d = cur_code_q;
    cur_ext_d = cur_ext_q;
    cur_ascii_d = cur_ascii_q;
    key_count_d = key_count_q;
    press_pulse_d = 1'b0;
    // the byte is consumed at the edge that closes the single pop cycle
    if (state_q == POP) begin
      if (ps2_data_i == 8'hE0) ext_pend_d = 1'b1;
      else if (ps2_data_i == 8'hF0) brk_pend_d = 1'b1;
      else if (brk_pend_q) begin
        key_down_d = same ? 1'b0 : key_down_q;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end else begin
        ext_pend_d = 1'b0;
        if (!same) begin
          cur_code_d = ps2_data_i;
          cur_ext_d = ext_pend_q;
          cur_ascii_d = ext_pend_q ? 8'h00 : to_ascii(ps2_data_i);
          key_down_d = 1'b1;
          key_count_d = key_count_q + COUNT_W'(1);
          press_pulse_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      nextdata_n_q <= 1'b1;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      key_down_q <= 1'b0;
      cur_code_q <= 8'h00;
      cur_ext_q <= 1'b0;
      cur_ascii_q <= 8'h00;
      key_count_q <= '0;
      press_pulse_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nextdata_n_q <= nextdata_n_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      key_down_q <= key_down_d;
      cur_code_q <= cur_code_d;
      cur_ext_q <= cur_ext_d;
      cur_ascii_q <= cur_ascii_d;
      key_count_q <= key_count_d;
      press_pulse_q <= press_pulse_d;
      err_q <= err_d;
    end
  end
  assign nextdata_n = nextdata_n_q;
  assign key_down = key_down_q;
  assign cur_code = cur_code_q;
  assign cur_ext = cur_ext_q;
  assign cur_ascii = cur_ascii_q;
  assign key_count = key_count_q;
  assign press_pulse = press_pulse_q;
  assign err_overflow = err_q;
endmodule
